// File: rtl/axi4_stream_scb_pkg.sv
// Shared types and helpers for the AXI4-Stream scoreboard.
// The beat struct is sized for the widest supported stream; narrower streams zero-extend into it.
package axi4_stream_scb_pkg;
  localparam int DN_MAX    = 32;
  localparam int UW_MAX    = 32;
  localparam int CNT_W_MAX = 64;

  typedef struct packed {
    logic [8*DN_MAX-1:0] data;
    logic [DN_MAX-1:0]   keep;
    logic                last;
    logic [UW_MAX-1:0]   user;
  } axi4_stream_scb_beat_t;

  function automatic logic beat_match(input axi4_stream_scb_beat_t ex, input axi4_stream_scb_beat_t ac,
                                      input logic cmp_keep, input logic cmp_last, input logic cmp_user);
    logic ok;
    ok = 1'b1;
    if (cmp_keep) begin
      if (ex.keep != ac.keep) ok = 1'b0;
      for (int i = 0; i < DN_MAX; i++)
        if (ex.keep[i] && (ex.data[8*i +: 8] != ac.data[8*i +: 8])) ok = 1'b0;
    end else if (ex.data != ac.data) begin
      ok = 1'b0;
    end
    if (cmp_last && (ex.last != ac.last)) ok = 1'b0;
    if (cmp_user && (ex.user != ac.user)) ok = 1'b0;
    return ok;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] v, input int w);
    logic [CNT_W_MAX-1:0] max;
    max = {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - w);
    return (v >= max) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/axi4_stream_scb_fifo.sv
// Synchronous FIFO with first-word-fall-through head; extra pointer MSB separates full from empty.
module axi4_stream_scb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         wr_ok, rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // A write into a full FIFO is accepted when the head leaves in the same cycle.
  assign wr_ok   = wr_en & (~full | rd_en);
  assign rd_ok   = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/axi4_stream_scoreboard.sv
// Passive AXI4-Stream scoreboard: buffers expected-tap beats and checks each actual-tap beat
// against the oldest one, with counters and first-error capture.
module axi4_stream_scoreboard
  import axi4_stream_scb_pkg::*;
#(
  parameter int DN       = 1,
  parameter int UW       = 1,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 32,
  parameter int CMP_KEEP = 1,
  parameter int CMP_LAST = 1,
  parameter int CMP_USER = 0
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     clr,
  input  logic                     exp_tvalid,
  input  logic                     exp_tready,
  input  logic [8*DN-1:0]          exp_tdata,
  input  logic [DN-1:0]            exp_tkeep,
  input  logic                     exp_tlast,
  input  logic [UW-1:0]            exp_tuser,
  input  logic                     act_tvalid,
  input  logic                     act_tready,
  input  logic [8*DN-1:0]          act_tdata,
  input  logic [DN-1:0]            act_tkeep,
  input  logic                     act_tlast,
  input  logic [UW-1:0]            act_tuser,
  output logic                     cmp_valid,
  output logic                     cmp_pass,
  output logic [CNT_W-1:0]         cmp_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         pkt_cnt,
  output logic                     ovf,
  output logic                     unf,
  output logic                     err_first,
  output logic [CNT_W-1:0]         err_beat,
  output logic [8*DN-1:0]          err_exp_data,
  output logic [8*DN-1:0]          err_act_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);
  localparam int FW = 8*DN + DN + 1 + UW;

  logic push, pop, bypass, unexp, wr_en, rd_en, full, empty, match, fail, drop;
  logic [FW-1:0] head;
  axi4_stream_scb_beat_t e_in, e_head, e_cmp, a_in;
  logic [CNT_W_MAX-1:0] cmp_nx, err_nx, pkt_nx;

  assign push   = exp_tvalid & exp_tready;
  assign pop    = act_tvalid & act_tready;
  // Empty FIFO with both taps firing: compare straight against the incoming expected beat.
  assign bypass = push & pop & empty;
  assign unexp  = pop & empty & ~push;
  assign wr_en  = push & ~bypass;
  assign rd_en  = pop & ~empty;
  assign drop   = wr_en & full & ~pop;

  axi4_stream_scb_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk(ACLK), .rst_n(ARESETn), .clr(clr),
    .wr_en(wr_en), .wr_data({exp_tdata, exp_tkeep, exp_tlast, exp_tuser}),
    .rd_en(rd_en), .rd_data(head),
    .full(full), .empty(empty), .level(level)
  );

  always_comb begin
    e_in   = '0;
    e_head = '0;
    a_in   = '0;
    e_in.data[8*DN-1:0]   = exp_tdata;
    e_in.keep[DN-1:0]     = exp_tkeep;
    e_in.last             = exp_tlast;
    e_in.user[UW-1:0]     = exp_tuser;
    e_head.data[8*DN-1:0] = head[FW-1 -: 8*DN];
    e_head.keep[DN-1:0]   = head[UW+1 +: DN];
    e_head.last           = head[UW];
    e_head.user[UW-1:0]   = head[UW-1:0];
    a_in.data[8*DN-1:0]   = act_tdata;
    a_in.keep[DN-1:0]     = act_tkeep;
    a_in.last             = act_tlast;
    a_in.user[UW-1:0]     = act_tuser;
    e_cmp = empty ? e_in : e_head;
  end

  assign match  = beat_match(e_cmp, a_in, CMP_KEEP != 0, CMP_LAST != 0, CMP_USER != 0);
  assign fail   = pop & (unexp | ~match);
  assign cmp_nx = sat_inc(CNT_W_MAX'(cmp_cnt), CNT_W);
  assign err_nx = sat_inc(CNT_W_MAX'(err_cnt), CNT_W);
  assign pkt_nx = sat_inc(CNT_W_MAX'(pkt_cnt), CNT_W);
  assign idle   = (level == '0) & ~cmp_valid;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cmp_valid <= 1'b0; cmp_pass <= 1'b0;
      cmp_cnt <= '0; err_cnt <= '0; pkt_cnt <= '0;
      ovf <= 1'b0; unf <= 1'b0; err_first <= 1'b0;
      err_beat <= '0; err_exp_data <= '0; err_act_data <= '0;
    end else if (clr) begin
      cmp_valid <= 1'b0; cmp_pass <= 1'b0;
      cmp_cnt <= '0; err_cnt <= '0; pkt_cnt <= '0;
      ovf <= 1'b0; unf <= 1'b0; err_first <= 1'b0;
      err_beat <= '0; err_exp_data <= '0; err_act_data <= '0;
    end else begin
      cmp_valid <= pop;
      cmp_pass  <= pop & ~fail;
      if (pop)             cmp_cnt <= cmp_nx[CNT_W-1:0];
      if (fail)            err_cnt <= err_nx[CNT_W-1:0];
      if (pop & act_tlast) pkt_cnt <= pkt_nx[CNT_W-1:0];
      if (drop)  ovf <= 1'b1;
      if (unexp) unf <= 1'b1;
      if (fail && !err_first) begin
        err_first    <= 1'b1;
        err_beat     <= cmp_cnt;
        err_exp_data <= unexp ? '0 : e_cmp.data[8*DN-1:0];
        err_act_data <= act_tdata;
      end
    end
  end
endmodule

// File: tb/tb_axi4_stream_scoreboard.sv
// Directed bench: DUT A (DN=1, DEPTH=16) for streaming/error/reset scenarios,
// DUT B (DN=4, DEPTH=4, CNT_W=3) for keep masking, overflow/underflow and saturation.
module tb_axi4_stream_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr_a, clr_b, rdy;
  int errors = 0;
  int checks = 0;

  logic        ea_v, ea_l, aa_v, aa_l;
  logic [7:0]  ea_d, aa_d;
  logic        a_cv, a_cp, a_ovf, a_unf, a_ef, a_idle;
  logic [31:0] a_cmp, a_err, a_pkt, a_eb;
  logic [7:0]  a_eed, a_ead;
  logic [4:0]  a_lvl;

  logic        eb_v, ab_v;
  logic [31:0] eb_d, ab_d;
  logic [3:0]  eb_k, ab_k;
  logic        b_cv, b_cp, b_ovf, b_unf, b_ef, b_idle;
  logic [2:0]  b_cmp, b_err, b_pkt, b_eb;
  logic [31:0] b_eed, b_ead;
  logic [2:0]  b_lvl;

  axi4_stream_scoreboard #(.DN(1), .UW(1), .DEPTH(16), .CNT_W(32)) u_a (
    .ACLK(clk), .ARESETn(rst_n), .clr(clr_a),
    .exp_tvalid(ea_v), .exp_tready(rdy), .exp_tdata(ea_d), .exp_tkeep(1'b1),
    .exp_tlast(ea_l), .exp_tuser(1'b0),
    .act_tvalid(aa_v), .act_tready(rdy), .act_tdata(aa_d), .act_tkeep(1'b1),
    .act_tlast(aa_l), .act_tuser(1'b0),
    .cmp_valid(a_cv), .cmp_pass(a_cp), .cmp_cnt(a_cmp), .err_cnt(a_err), .pkt_cnt(a_pkt),
    .ovf(a_ovf), .unf(a_unf), .err_first(a_ef), .err_beat(a_eb),
    .err_exp_data(a_eed), .err_act_data(a_ead), .level(a_lvl), .idle(a_idle)
  );

  axi4_stream_scoreboard #(.DN(4), .UW(1), .DEPTH(4), .CNT_W(3)) u_b (
    .ACLK(clk), .ARESETn(rst_n), .clr(clr_b),
    .exp_tvalid(eb_v), .exp_tready(rdy), .exp_tdata(eb_d), .exp_tkeep(eb_k),
    .exp_tlast(1'b1), .exp_tuser(1'b0),
    .act_tvalid(ab_v), .act_tready(rdy), .act_tdata(ab_d), .act_tkeep(ab_k),
    .act_tlast(1'b1), .act_tuser(1'b0),
    .cmp_valid(b_cv), .cmp_pass(b_cp), .cmp_cnt(b_cmp), .err_cnt(b_err), .pkt_cnt(b_pkt),
    .ovf(b_ovf), .unf(b_unf), .err_first(b_ef), .err_beat(b_eb),
    .err_exp_data(b_eed), .err_act_data(b_ead), .level(b_lvl), .idle(b_idle)
  );

  task automatic drv_a(input logic ev, input logic [7:0] ed, input logic el,
                       input logic av, input logic [7:0] ad, input logic al);
    ea_v = ev; ea_d = ed; ea_l = el; aa_v = av; aa_d = ad; aa_l = al;
    @(posedge clk); #1;
    ea_v = 1'b0; aa_v = 1'b0;
  endtask

  task automatic drv_b(input logic ev, input logic [31:0] ed, input logic [3:0] ek,
                       input logic av, input logic [31:0] ad, input logic [3:0] ak);
    eb_v = ev; eb_d = ed; eb_k = ek; ab_v = av; ab_d = ad; ab_k = ak;
    @(posedge clk); #1;
    eb_v = 1'b0; ab_v = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_a = 1'b1; clr_b = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0; clr_b = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({a_cmp, a_err, a_pkt, a_eb} !== 128'd0) begin
      errors++; $display("FAIL reset_cnt_a got %h %h %h %h want 0", a_cmp, a_err, a_pkt, a_eb);
    end
    checks++;
    if ({a_cv, a_cp, a_ovf, a_unf, a_ef, a_lvl, a_idle} !== {5'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL reset_flags_a got cv%b cp%b o%b u%b ef%b lvl%0d idle%b want all0 idle1",
                          a_cv, a_cp, a_ovf, a_unf, a_ef, a_lvl, a_idle);
    end
    checks++;
    if ({b_cmp, b_err, b_pkt, b_lvl, b_ovf, b_unf, b_idle} !== {12'd0, 2'b0, 1'b1}) begin
      errors++; $display("FAIL reset_b got cmp%0d err%0d pkt%0d lvl%0d o%b u%b idle%b",
                          b_cmp, b_err, b_pkt, b_lvl, b_ovf, b_unf, b_idle);
    end
  endtask

  task automatic test_bypass();
    int lvl_bad = 0;
    int passes = 0;
    pulse_clr();
    for (int p = 0; p < 5; p++)
      for (int b = 0; b < 4; b++) begin
        drv_a(1'b1, 8'(p*4 + b), b == 3, 1'b1, 8'(p*4 + b), b == 3);
        if (a_lvl !== 5'd0) lvl_bad++;
        if (a_cv === 1'b1 && a_cp === 1'b1) passes++;
      end
    checks++;
    if ({a_cmp, a_err, a_pkt} !== {32'd20, 32'd0, 32'd5}) begin
      errors++; $display("FAIL bypass_cnt got cmp=%0d err=%0d pkt=%0d want 20 0 5", a_cmp, a_err, a_pkt);
    end
    checks++;
    if (lvl_bad != 0 || passes != 20) begin
      errors++; $display("FAIL bypass_level got lvl_nonzero=%0d passes=%0d want 0 20", lvl_bad, passes);
    end
    checks++;
    if ({a_ovf, a_unf} !== 2'b00) begin
      errors++; $display("FAIL bypass_flags got ovf=%b unf=%b want 0 0", a_ovf, a_unf);
    end
  endtask

  task automatic test_lead();
    int peak = 0;
    int passes = 0;
    pulse_clr();
    for (int i = 0; i < 28; i++) begin
      drv_a(i < 20, 8'(i), (i % 4) == 3, i >= 8, 8'(i - 8), (i >= 8) && (((i - 8) % 4) == 3));
      if (int'(a_lvl) > peak) peak = int'(a_lvl);
      if (a_cv === 1'b1 && a_cp === 1'b1) passes++;
    end
    checks++;
    if (peak != 8 || passes != 20) begin
      errors++; $display("FAIL lead_peak got peak=%0d passes=%0d want 8 20", peak, passes);
    end
    checks++;
    if ({a_err, a_pkt, a_idle} !== {32'd0, 32'd5, 1'b0}) begin
      errors++; $display("FAIL lead_last got err=%0d pkt=%0d idle=%b want 0 5 0", a_err, a_pkt, a_idle);
    end
    drv_a(1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0);
    checks++;
    if ({a_lvl, a_idle} !== {5'd0, 1'b1}) begin
      errors++; $display("FAIL lead_idle got lvl=%0d idle=%b want 0 1", a_lvl, a_idle);
    end
  endtask

  task automatic test_corrupt();
    logic [7:0] e, a;
    pulse_clr();
    for (int k = 1; k <= 15; k++) begin
      e = 8'h35 + 8'(k);
      a = (k == 7) ? 8'h3D : (k == 12) ? (e ^ 8'h01) : e;
      drv_a(1'b1, e, 1'b0, 1'b1, a, 1'b0);
      if (k == 7) begin
        checks++;
        if ({a_cv, a_cp, a_err, a_eb, a_ef} !== {2'b10, 32'd1, 32'd6, 1'b1}) begin
          errors++; $display("FAIL corrupt_first got cv%b cp%b err=%0d beat=%0d ef=%b want 1 0 1 6 1",
                              a_cv, a_cp, a_err, a_eb, a_ef);
        end
      end
    end
    checks++;
    if ({a_cmp, a_err, a_eb} !== {32'd15, 32'd2, 32'd6}) begin
      errors++; $display("FAIL corrupt_cnt got cmp=%0d err=%0d beat=%0d want 15 2 6", a_cmp, a_err, a_eb);
    end
    checks++;
    if ({a_eed, a_ead} !== {8'h3C, 8'h3D}) begin
      errors++; $display("FAIL corrupt_capture got exp=%h act=%h want 3c 3d", a_eed, a_ead);
    end
  endtask

  task automatic test_keep();
    pulse_clr();
    drv_b(1'b1, 32'h1111AABB, 4'b0011, 1'b1, 32'h2222AABB, 4'b0011);
    checks++;
    if ({b_cv, b_cp} !== 2'b11) begin
      errors++; $display("FAIL keep_masked got cv%b cp%b want 1 1", b_cv, b_cp);
    end
    drv_b(1'b1, 32'h1111AABB, 4'b0011, 1'b1, 32'h1111AABB, 4'b0111);
    checks++;
    if ({b_cv, b_cp} !== 2'b10) begin
      errors++; $display("FAIL keep_diff got cv%b cp%b want 1 0", b_cv, b_cp);
    end
    drv_b(1'b1, 32'h1111AABB, 4'b0011, 1'b1, 32'h1111AABC, 4'b0011);
    checks++;
    if ({b_cv, b_cp, b_err} !== {2'b10, 3'd2}) begin
      errors++; $display("FAIL keep_byte got cv%b cp%b err=%0d want 1 0 2", b_cv, b_cp, b_err);
    end
  endtask

  task automatic test_ovf_unf();
    int passes = 0;
    pulse_clr();
    for (int i = 0; i < 5; i++) drv_b(1'b1, 32'(i), 4'hF, 1'b0, 32'h0, 4'hF);
    checks++;
    if ({b_lvl, b_ovf, b_unf, b_err} !== {3'd4, 2'b10, 3'd0}) begin
      errors++; $display("FAIL ovf got lvl=%0d ovf=%b unf=%b err=%0d want 4 1 0 0", b_lvl, b_ovf, b_unf, b_err);
    end
    drv_b(1'b1, 32'd5, 4'hF, 1'b1, 32'd0, 4'hF);
    checks++;
    if ({b_lvl, b_cv, b_cp} !== {3'd4, 2'b11}) begin
      errors++; $display("FAIL full_pushpop got lvl=%0d cv%b cp%b want 4 1 1", b_lvl, b_cv, b_cp);
    end
    drv_b(1'b0, 32'h0, 4'hF, 1'b1, 32'd1, 4'hF); if (b_cp === 1'b1) passes++;
    drv_b(1'b0, 32'h0, 4'hF, 1'b1, 32'd2, 4'hF); if (b_cp === 1'b1) passes++;
    drv_b(1'b0, 32'h0, 4'hF, 1'b1, 32'd3, 4'hF); if (b_cp === 1'b1) passes++;
    drv_b(1'b0, 32'h0, 4'hF, 1'b1, 32'd5, 4'hF); if (b_cp === 1'b1) passes++;
    checks++;
    if (passes != 4 || b_lvl !== 3'd0 || b_err !== 3'd0) begin
      errors++; $display("FAIL drain got passes=%0d lvl=%0d err=%0d want 4 0 0", passes, b_lvl, b_err);
    end
    drv_b(1'b0, 32'h0, 4'hF, 1'b1, 32'h77, 4'hF);
    checks++;
    if ({b_unf, b_cv, b_cp, b_err, b_eb} !== {3'b110, 3'd1, 3'd5}) begin
      errors++; $display("FAIL unf got unf=%b cv%b cp%b err=%0d beat=%0d want 1 1 0 1 5",
                          b_unf, b_cv, b_cp, b_err, b_eb);
    end
    checks++;
    if ({b_eed, b_ead} !== {32'h0, 32'h77}) begin
      errors++; $display("FAIL unf_capture got exp=%h act=%h want 0 77", b_eed, b_ead);
    end
  endtask

  task automatic test_saturate();
    pulse_clr();
    for (int i = 0; i < 10; i++) drv_b(1'b1, 32'(i), 4'hF, 1'b1, 32'(i), 4'hF);
    checks++;
    if ({b_cmp, b_pkt, b_err} !== {3'd7, 3'd7, 3'd0}) begin
      errors++; $display("FAIL saturate got cmp=%0d pkt=%0d err=%0d want 7 7 0", b_cmp, b_pkt, b_err);
    end
  endtask

  task automatic test_reset_mid();
    pulse_clr();
    drv_a(1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 3; i++) drv_a(1'b1, 8'(i), 1'b0, 1'b0, 8'h0, 1'b0);
    checks++;
    if ({a_lvl, a_cmp, a_idle} !== {5'd3, 32'd1, 1'b0}) begin
      errors++; $display("FAIL pre_reset got lvl=%0d cmp=%0d idle=%b want 3 1 0", a_lvl, a_cmp, a_idle);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_lvl, a_cmp, a_idle} !== {5'd0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL async_reset got lvl=%0d cmp=%0d idle=%b want 0 0 1", a_lvl, a_cmp, a_idle);
    end
    rst_n = 1'b1;
    drv_a(1'b1, 8'h42, 1'b1, 1'b1, 8'h42, 1'b1);
    checks++;
    if ({a_cv, a_cp, a_cmp, a_pkt} !== {2'b11, 32'd1, 32'd1}) begin
      errors++; $display("FAIL post_reset got cv%b cp%b cmp=%0d pkt=%0d want 1 1 1 1", a_cv, a_cp, a_cmp, a_pkt);
    end
  endtask

  task automatic test_clr();
    pulse_clr();
    drv_a(1'b0, 8'h0, 1'b0, 1'b1, 8'h01, 1'b0);
    drv_a(1'b0, 8'h0, 1'b0, 1'b1, 8'h02, 1'b0);
    checks++;
    if ({a_err, a_unf, a_ef} !== {32'd2, 2'b11}) begin
      errors++; $display("FAIL pre_clr got err=%0d unf=%b ef=%b want 2 1 1", a_err, a_unf, a_ef);
    end
    clr_a = 1'b1;
    drv_a(1'b0, 8'h0, 1'b0, 1'b1, 8'h05, 1'b1);
    clr_a = 1'b0;
    checks++;
    if ({a_cmp, a_err, a_pkt, a_cv, a_unf, a_ef, a_lvl, a_idle} !== {96'd0, 3'b000, 5'd0, 1'b1}) begin
      errors++; $display("FAIL clr got cmp=%0d err=%0d pkt=%0d cv%b unf%b ef%b lvl=%0d idle=%b",
                          a_cmp, a_err, a_pkt, a_cv, a_unf, a_ef, a_lvl, a_idle);
    end
    drv_a(1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1'b0);
    checks++;
    if ({a_cv, a_cp, a_err, a_cmp} !== {2'b11, 32'd0, 32'd1}) begin
      errors++; $display("FAIL post_clr got cv%b cp%b err=%0d cmp=%0d want 1 1 0 1", a_cv, a_cp, a_err, a_cmp);
    end
  endtask

  initial begin
    rdy = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    ea_v = 1'b0; ea_d = '0; ea_l = 1'b0; aa_v = 1'b0; aa_d = '0; aa_l = 1'b0;
    eb_v = 1'b0; eb_d = '0; eb_k = '0; ab_v = 1'b0; ab_d = '0; ab_k = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_bypass();
    test_lead();
    test_corrupt();
    test_keep();
    test_ovf_unf();
    test_saturate();
    test_reset_mid();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
